// File: rtl/din_syn_serializer.sv
// Purpose: bit-serial DIN/SYN pattern generator with gated sclk, optional repeat frames;
//          optional per-lane even parity bit when DIN_SYN_PARITY_EN is defined.
// Latency: bit 0 appears on din one cycle after the trig rising edge; done one cycle after last SYNC cycle.
// Backpressure: none; trig edges while busy are dropped, inputs are shadowed at start.
module din_syn_serializer #(
    parameter int NBITS = 491,
    parameter int NCH   = 1,
    parameter int DIV   = 2
) (
    input  logic                 clk_in,
    input  logic                 dump,
    input  logic [NCH*NBITS-1:0] data_reg,
    input  logic                 trig,
    input  logic [1:0]           clr_mode,
    input  logic                 msb_first,
    input  logic [7:0]           repeat_cnt,
    output logic                 sclk,
    output logic [NCH-1:0]       din,
    output logic                 syn,
    output logic                 out_en,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(NBITS + 2);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef DIN_SYN_PARITY_EN
    localparam int LASTK = NBITS;
`else
    localparam int LASTK = NBITS - 1;
`endif
    localparam logic [BW-1:0] LAST_BIT = BW'(LASTK);
    localparam logic [BW-1:0] MSB_IDX  = BW'(NBITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SYNC  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 trig_q;
    logic [NCH*NBITS-1:0] data_q;
    logic                 msb_q;
    logic [1:0]           clr_q;
    logic [7:0]           rep_q;
    logic [7:0]           frame_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DW-1:0]        div_cnt;
    logic                 phase;
    logic                 done_nxt;
    logic                 done_q;
    logic                 start;
    logic                 period_end;
    logic                 last_frame;
    logic [BW-1:0]        bit_idx;
    logic [NCH-1:0]       lane_bit;
    logic [NCH-1:0]       shift_bits;

    assign start      = trig & ~trig_q;
    // phase is the sclk level; a bit period ends on the last cycle of the high half
    assign period_end = phase & (div_cnt == DIV_LAST);
    assign last_frame = (frame_cnt >= rep_q);
    assign bit_idx    = msb_q ? (MSB_IDX - bit_cnt) : bit_cnt;
    assign done       = done_q;

    // per-lane data bit selection (and parity bit in the extra period when enabled)
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        logic [NBITS-1:0] lane;
        logic [NBITS-1:0] lane_shr;
        assign lane     = data_q[c*NBITS +: NBITS];
        assign lane_shr = lane >> bit_idx;
`ifdef DIN_SYN_PARITY_EN
        assign lane_bit[c] = (bit_cnt == BW'(NBITS)) ? (^lane) : lane_shr[0];
`else
        assign lane_bit[c] = lane_shr[0];
`endif
    end

    // clr_mode override: 01 forces ones, 11 forces zeros, 00/10 pass data
    always_comb begin
        shift_bits = lane_bit;
        if (clr_q == 2'b01) begin
            shift_bits = '1;
        end else if (clr_q == 2'b11) begin
            shift_bits = '0;
        end
    end

    // state register
    always_ff @(posedge clk_in or posedge dump) begin
        if (dump) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic and done pulse request
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (period_end && (bit_cnt == LAST_BIT)) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (period_end) begin
                    if (last_frame) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (period_end) begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output decode from state only, so dump clears the pads in the same cycle
    always_comb begin
        sclk   = 1'b0;
        din    = '0;
        syn    = 1'b0;
        out_en = 1'b0;
        busy   = 1'b0;
        case (state)
            SHIFT: begin
                out_en = 1'b1;
                busy   = 1'b1;
                sclk   = phase;
                din    = shift_bits;
            end
            SYNC: begin
                out_en = 1'b1;
                busy   = 1'b1;
                sclk   = phase;
                syn    = ~clr_q[0];
            end
            GAP: begin
                out_en = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                out_en = 1'b0;
            end
        endcase
    end

    // trig history and done pulse; history resets high so a trig held through dump must rise again
    always_ff @(posedge clk_in or posedge dump) begin
        if (dump) begin
            trig_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            trig_q <= trig;
            done_q <= done_nxt;
        end
    end

    // shadow registers captured on an accepted start
    always_ff @(posedge clk_in or posedge dump) begin
        if (dump) begin
            data_q <= '0;
            msb_q  <= 1'b0;
            clr_q  <= 2'b00;
            rep_q  <= 8'd0;
        end else if ((state == IDLE) && start) begin
            data_q <= data_reg;
            msb_q  <= msb_first;
            clr_q  <= clr_mode;
            rep_q  <= repeat_cnt;
        end
    end

    // divider, bit and frame counters; held cleared while idle
    always_ff @(posedge clk_in or posedge dump) begin
        if (dump) begin
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= 8'd0;
        end else if (state == IDLE) begin
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= 8'd0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if ((state == SHIFT) && period_end) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            if ((state == SYNC) && period_end && !last_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_din_syn_serializer.sv
// Purpose: directed self-checking bench for din_syn_serializer (NBITS=8, NCH=2, DIV=2).
// Latency: checks every cycle of each sequence against hand-written lane patterns.
// Backpressure: n/a; covers ignored mid-frame trig, repeat frames, clr modes and dump.
module tb_din_syn_serializer;

    localparam int NBITS = 8;
    localparam int NCH   = 2;
    localparam int DIV   = 2;
`ifdef DIN_SYN_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PER = 2 * DIV;
    localparam int FL  = (NBITS + P + 1) * PER;

    logic                 clk_in = 1'b0;
    logic                 dump;
    logic [NCH*NBITS-1:0] data_reg;
    logic                 trig;
    logic [1:0]           clr_mode;
    logic                 msb_first;
    logic [7:0]           repeat_cnt;
    logic                 sclk;
    logic [NCH-1:0]       din;
    logic                 syn;
    logic                 out_en;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    din_syn_serializer #(.NBITS(NBITS), .NCH(NCH), .DIV(DIV)) dut (
        .clk_in     (clk_in),
        .dump       (dump),
        .data_reg   (data_reg),
        .trig       (trig),
        .clr_mode   (clr_mode),
        .msb_first  (msb_first),
        .repeat_cnt (repeat_cnt),
        .sclk       (sclk),
        .din        (din),
        .syn        (syn),
        .out_en     (out_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // s0/s1: lane bits in transmission order, MSB of the vector sent first
    task automatic run_frame(input logic [15:0] d, input logic msb, input logic [1:0] clr,
                             input logic [7:0] rep, input logic [7:0] s0, input logic [7:0] s1,
                             input logic p0, input logic p1, input bit disturb);
        int frames, step, total, m, p, c;
        int ebusy, edone, esclk, edin, esyn;
        logic [7:0] t0, t1;
        @(negedge clk_in);
        data_reg   = d;
        msb_first  = msb;
        clr_mode   = clr;
        repeat_cnt = rep;
        trig       = 1'b1;
        @(negedge clk_in);
        trig   = 1'b0;
        frames = int'(rep) + 1;
        step   = FL + PER;
        total  = frames * FL + (frames - 1) * PER;
        for (int n = 1; n <= total + 1; n++) begin
            if (n > 1) @(negedge clk_in);
            m     = (n - 1) % step;
            ebusy = (n <= total) ? 1 : 0;
            edone = (n == total + 1) ? 1 : 0;
            esclk = 0;
            edin  = 0;
            esyn  = 0;
            if (ebusy == 1 && m < FL) begin
                p     = m / PER;
                c     = m % PER;
                esclk = (c >= DIV) ? 1 : 0;
                if (p < NBITS) begin
                    t0   = s0 >> (7 - p);
                    t1   = s1 >> (7 - p);
                    edin = 2 * int'(t1[0]) + int'(t0[0]);
                end else if (P == 1 && p == NBITS) begin
                    edin = 2 * int'(p1) + int'(p0);
                end else begin
                    esyn = (clr[0] == 1'b1) ? 0 : 1;
                end
            end
            check("busy",   32'(busy),   ebusy);
            check("out_en", 32'(out_en), ebusy);
            check("done",   32'(done),   edone);
            check("sclk",   32'(sclk),   esclk);
            check("din",    32'(din),    edin);
            check("syn",    32'(syn),    esyn);
            if (disturb) begin
                if (n == 5) begin
                    data_reg   = ~d;
                    msb_first  = ~msb;
                    clr_mode   = 2'b01;
                    repeat_cnt = 8'd5;
                end
                if (n == 10) trig = 1'b1;
                if (n == 11) trig = 1'b0;
            end
        end
        @(negedge clk_in);
        check("done_one_pulse", 32'(done), 0);
        check("idle_busy",      32'(busy), 0);
    endtask

    initial begin
        dump       = 1'b1;
        data_reg   = '0;
        trig       = 1'b0;
        clr_mode   = 2'b00;
        msb_first  = 1'b1;
        repeat_cnt = 8'd0;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", 32'({sclk, din, syn, out_en, busy, done}), 0);
        dump = 1'b0;
        repeat (2) @(negedge clk_in);
        check("idle_outputs", 32'({sclk, din, syn, out_en, busy, done}), 0);

        // A55A both orders (palindromic bytes), then 0307 which distinguishes order
        run_frame(16'hA55A, 1'b1, 2'b00, 8'd0, 8'b01011010, 8'b10100101, 1'b0, 1'b0, 1'b0);
        run_frame(16'hA55A, 1'b0, 2'b00, 8'd0, 8'b01011010, 8'b10100101, 1'b0, 1'b0, 1'b0);
        run_frame(16'h0307, 1'b1, 2'b00, 8'd0, 8'b00000111, 8'b00000011, 1'b1, 1'b0, 1'b0);
        run_frame(16'h0307, 1'b0, 2'b00, 8'd0, 8'b11100000, 8'b11000000, 1'b1, 1'b0, 1'b0);
        // three frames, clr_mode 10 behaves as normal
        run_frame(16'hA55A, 1'b1, 2'b10, 8'd2, 8'b01011010, 8'b10100101, 1'b0, 1'b0, 1'b0);
        // forced ones, forced zeros
        run_frame(16'h0307, 1'b1, 2'b01, 8'd0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        run_frame(16'h0307, 1'b1, 2'b11, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        // mid-sequence trig and input changes must be ignored
        run_frame(16'h0307, 1'b1, 2'b00, 8'd1, 8'b00000111, 8'b00000011, 1'b1, 1'b0, 1'b1);

        // dump during bit 3 while sclk is high
        @(negedge clk_in);
        data_reg   = 16'h0307;
        msb_first  = 1'b1;
        clr_mode   = 2'b00;
        repeat_cnt = 8'd0;
        trig       = 1'b1;
        @(negedge clk_in);
        trig = 1'b0;
        repeat (14) @(negedge clk_in);
        check("pre_dump_sclk", 32'(sclk), 1);
        check("pre_dump_din",  32'(din),  0);
        check("pre_dump_busy", 32'(busy), 1);
        #2 dump = 1'b1;
        #1;
        check("dump_outputs", 32'({sclk, din, syn, out_en, busy, done}), 0);
        @(negedge clk_in);
        dump = 1'b0;
        repeat (2) @(negedge clk_in);
        check("post_dump_idle", 32'({sclk, din, syn, out_en, busy, done}), 0);
        run_frame(16'h0307, 1'b1, 2'b00, 8'd0, 8'b00000111, 8'b00000011, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
